// File: rtl/pixel_cmd_writer.sv
// pixel_cmd_writer: turns start/done drawing commands into frame RAM writes.
// Optional HLINE_CLIP_EN: LINE stops at the end of its starting row.
module pixel_cmd_writer #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic [ADDR_W-1:0] wraddress,
    output logic              data,
    output logic              wren,
    output logic [31:0]       result,
    output logic              done,
    output logic              busy
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] FILL_N = CW'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE,
        PIXEL,
        FILL,
        LINE,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              data_q, data_d;
    logic              wren_q, wren_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     tgt_q, tgt_d;
    logic [31:0]       total_q, total_d;
    logic [31:0]       result_q, result_d;

    logic [XW-1:0]     cmd_x;
    logic [YW-1:0]     cmd_y;
    logic [1:0]        cmd_op;
    logic              cmd_val;
    logic [11:0]       cmd_len;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CW-1:0]     line_n;
    logic              unused_bits;

    assign cmd_x    = dataa[XW-1:0];
    assign cmd_y    = dataa[XW+YW-1:XW];
    assign cmd_op   = datab[1:0];
    assign cmd_val  = datab[2];
    assign cmd_len  = datab[14:3];
    assign cmd_addr = {cmd_y, cmd_x};

    assign unused_bits = ^{dataa[31:ADDR_W], datab[31:15]};

`ifdef HLINE_CLIP_EN
    logic [CW-1:0] row_left;

    // Pixels left in the starting row, including the start column.
    assign row_left = CW'(IMG_W) - CW'(cmd_x);
    assign line_n   = (CW'(cmd_len) < row_left) ? CW'(cmd_len) : row_left;
`else
    assign line_n = CW'(cmd_len);
`endif

    // Command sequencing: each write state emits one RAM write per cycle
    // until the per-command count reaches the latched target.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        total_d  = total_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    data_d = cmd_val;
                    unique case (cmd_op)
                        2'd0: begin
                            state_d = PIXEL;
                            addr_d  = cmd_addr;
                            tgt_d   = CW'(1);
                            wren_d  = 1'b1;
                        end
                        2'd1: begin
                            state_d = FILL;
                            addr_d  = '0;
                            tgt_d   = FILL_N;
                            wren_d  = 1'b1;
                        end
                        2'd2: begin
                            if (line_n == '0) begin
                                state_d  = FINISH;
                                result_d = '0;
                            end else begin
                                state_d = LINE;
                                addr_d  = cmd_addr;
                                tgt_d   = line_n;
                                wren_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d  = FINISH;
                            result_d = total_q;
                        end
                    endcase
                end
            end
            PIXEL, FILL, LINE: begin
                cnt_d   = cnt_q + CW'(1);
                total_d = total_q + 32'd1;
                if (cnt_d == tgt_q) begin
                    state_d  = FINISH;
                    result_d = 32'(cnt_d);
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    wren_d = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered RAM port; reset drops wren at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= 1'b0;
            wren_q   <= 1'b0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            total_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            total_q  <= total_d;
            result_q <= result_d;
        end
    end

    assign wraddress = addr_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign result    = result_q;
    assign done      = (state_q == FINISH);
    assign busy      = (state_q == PIXEL) || (state_q == FILL) ||
                       (state_q == LINE);

endmodule

// File: tb/tb_pixel_cmd_writer.sv
// tb_pixel_cmd_writer: random and directed commands against a write-list model.
// Expectations follow HLINE_CLIP_EN when it is defined for the build.
module tb_pixel_cmd_writer;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   dataa = '0;
    logic [31:0]   datab = '0;
    logic [AW-1:0] wraddress;
    logic          data;
    logic          wren;
    logic [31:0]   result;
    logic          done;
    logic          busy;

    int            n_chk = 0;
    int            n_bad = 0;
    int unsigned   exp_q[$];
    logic [31:0]   exp_res;
    int unsigned   model_total = 0;

    pixel_cmd_writer #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dataa    (dataa),
        .datab    (datab),
        .wraddress(wraddress),
        .data     (data),
        .wren     (wren),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mka(input int x, input int y);
        logic [31:0] r;
        r = $urandom & 32'hFFFF_F000;
        return r | 32'(y * W + x);
    endfunction

    function automatic logic [31:0] mkb(input int op, input int val,
                                        input int len);
        logic [31:0] r;
        r = $urandom & 32'hFFFF_8000;
        return r | 32'(len << 3) | 32'(val << 2) | 32'(op);
    endfunction

    // Expected write list and result for one command, from the rules.
    function automatic void build(input logic [31:0] a, input logic [31:0] b);
        int op, x, y, len, n;
        op  = int'(b[1:0]);
        x   = int'(a[5:0]);
        y   = int'(a[11:6]);
        len = int'(b[14:3]);
        exp_q.delete();
        if (op == 0) begin
            exp_q.push_back(y * W + x);
        end else if (op == 1) begin
            for (int i = 0; i < W * H; i++) exp_q.push_back(i);
        end else if (op == 2) begin
            n = len;
`ifdef HLINE_CLIP_EN
            if (W - x < n) n = W - x;
`endif
            for (int i = 0; i < n; i++)
                exp_q.push_back((y * W + x + i) % (W * H));
        end
        exp_res = (op == 3) ? model_total : 32'(exp_q.size());
        model_total += exp_q.size();
    endfunction

    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b,
                          input bit spam, input string tag);
        int n, dcyc, wcnt, werr, berr, aerr, derr;
        logic [31:0] rseen;
        logic val;
        build(a, b);
        n = exp_q.size();
        val = b[2];
        dcyc = -1;
        wcnt = 0; werr = 0; berr = 0; aerr = 0; derr = 0;
        rseen = '0;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= n + 8; i++) begin
            @(negedge clk);
            if (spam && i + 2 < n) begin
                start = 1'($urandom_range(0, 1));
                dataa = $urandom;
                datab = $urandom;
            end else begin
                start = 1'b0;
            end
            if (wren !== (i <= n)) werr++;
            if (busy !== (i <= n)) berr++;
            if (wren === 1'b1 && i <= n) begin
                if (32'(wraddress) !== exp_q[i-1]) aerr++;
                if (data !== val) derr++;
                wcnt++;
            end
            if (done === 1'b1) begin
                dcyc = i;
                rseen = result;
                break;
            end
        end
        check({tag, "_done_lat"}, dcyc, n + 1);
        check({tag, "_writes"}, wcnt, n);
        check({tag, "_wren_err"}, werr, 0);
        check({tag, "_busy_err"}, berr, 0);
        check({tag, "_addr_err"}, aerr, 0);
        check({tag, "_data_err"}, derr, 0);
        check({tag, "_result"}, rseen, exp_res);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    initial begin
        int cnt;
        bit seen;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        check("rst_wren", {31'b0, wren}, 0);
        check("rst_data", {31'b0, data}, 0);
        check("rst_addr", 32'(wraddress), 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_result", result, 0);
        reset_n = 1'b1;

        do_cmd(mka(5, 3), mkb(0, 1, 0), 1'b0, "pixel");
        do_cmd(mka(0, 0), mkb(1, 0, 0), 1'b0, "fill");
        do_cmd(mka(0, 0), mkb(3, 0, 0), 1'b0, "status1");
        do_cmd(mka(60, 2), mkb(2, 1, 10), 1'b0, "line60");
        do_cmd(mka(63, 63), mkb(2, 1, 3), 1'b0, "linewrap");
        do_cmd(mka(17, 40), mkb(2, 1, 0), 1'b0, "line0");
        do_cmd(mka(0, 0), mkb(1, 1, 0), 1'b1, "fillspam");
        do_cmd(mka(9, 9), mkb(3, 1, 0), 1'b0, "status2");

        // start held high across done re-triggers right after it
        a = mka(5, 3);
        b = mkb(0, 1, 0);
        build(a, b);
        build(a, b);
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_done1", {31'b0, seen}, 1);
        @(negedge clk);
        check("hold_idle_busy", {31'b0, busy}, 0);
        check("hold_idle_wren", {31'b0, wren}, 0);
        @(negedge clk);
        start = 1'b0;
        check("hold_rewren", {31'b0, wren}, 1);
        check("hold_rebusy", {31'b0, busy}, 1);
        check("hold_readdr", 32'(wraddress), 197);
        @(negedge clk);
        check("hold_done2", {31'b0, done}, 1);
        check("hold_result", result, 1);
        do_cmd(mka(0, 0), mkb(3, 0, 0), 1'b0, "status3");

        // reset in the middle of a fill
        @(negedge clk);
        dataa = mka(0, 0);
        datab = mkb(1, 1, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wren === 1'b1) cnt++;
            if (cnt == 100) break;
        end
        check("mid_wcnt", cnt, 100);
        #5 reset_n = 1'b0;
        #1;
        check("mid_wren", {31'b0, wren}, 0);
        check("mid_busy", {31'b0, busy}, 0);
        model_total = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_nodone", {31'b0, done}, 0);
        end
        reset_n = 1'b1;
        do_cmd(mka(1, 1), mkb(3, 0, 0), 1'b0, "status_rst");

        for (int r = 0; r < 40; r++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 1) op = 2;
            do_cmd(mka(int'($urandom_range(0, W - 1)),
                       int'($urandom_range(0, H - 1))),
                   mkb(op, int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 130))),
                   1'($urandom_range(0, 1)), "rand");
        end
        do_cmd(mka(0, 0), mkb(3, 0, 0), 1'b0, "status_end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_cmd_writer.md
Name: pixel_cmd_writer

Overview:
- Upstream writer for the 64x64 1-bit frame RAM that the VGA display stage scans out.
- Accepts drawing commands over a start/done custom-instruction handshake (dataa, datab, start, result, done).
- Converts each command into sequential single-port RAM writes (wraddress, data, wren).
- Supports four commands: single pixel, full-frame fill, horizontal line, and status readback.

Parameters:
- IMG_W, 64, image width in pixels; power of 2. XW = log2(IMG_W).
- IMG_H, 64, image height in pixels; power of 2. YW = log2(IMG_H).
- ADDR_W, 12, RAM address width; equals XW+YW.

Ports:
- clk  in  1  system clock (25 MHz pixel domain)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- dataa  in  32  [XW-1:0] = x, [XW+YW-1:XW] = y; other bits ignored
- datab  in  32  [1:0] = opcode, [2] = pixel value, [14:3] = line length L; other bits ignored
- wraddress  out  ADDR_W  RAM write address, = y*IMG_W + x
- data  out  1  RAM write data
- wren  out  1  RAM write enable
- result  out  32  command result
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after acceptance until done

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; wren=0, data=0, wraddress=0, done=0, busy=0.
  - result=0; cumulative write counter total=0.
- States: IDLE, PIXEL, FILL, LINE, FINISH.
- Command acceptance:
  - Rising edge with state=IDLE and start=1 latches dataa/datab and the value bit.
  - Clears the per-command write counter cnt (13 bit).
  - Next state is chosen from the opcode.
  - start outside IDLE is ignored, not queued.
  - start held high re-triggers on the first IDLE cycle after done.
- Opcode 0, PIXEL:
  - One write at (x,y).
  - Accept at edge k; wren=1 during cycle k+1; done during cycle k+2.
- Opcode 1, FILL:
  - Writes value to addresses 0..IMG_W*IMG_H-1 in ascending order, one per cycle.
  - wren high cycles k+1..k+4096; done at k+4097.
- Opcode 2, LINE:
  - Writes L pixels starting at address y*IMG_W+x, address incrementing by 1.
  - wren high cycles k+1..k+L; done at k+L+1.
  - L=0: no write; goes directly to FINISH; done at k+1.
  - Address is ADDR_W bits and wraps from 4095 to 0.
  - Without clipping, a line crossing the row end continues on the next row.
- Opcode 3, STATUS:
  - No write; done at k+1; result = total.
- FINISH:
  - done=1 for exactly one cycle; busy=0; returns to IDLE.
  - For opcodes 0-2, result = zero-extended cnt (writes actually performed).
  - result holds until the next FINISH.
- total:
  - 32-bit count of all RAM writes since reset; wraps modulo 2^32.
  - Incremented in the same cycle as each wren.
- wren/data/wraddress are registered outputs.
  - data equals the latched value bit during every write.
  - wraddress is undefined-but-stable when wren=0: it holds its last value.
- busy=1 in PIXEL, FILL, LINE; 0 in IDLE and FINISH.
- Reset mid-command:
  - wren drops immediately (async); no done is issued.
  - Partially written RAM content is left as is; total=0.

Optional Feature:
- Macro HLINE_CLIP_EN.
- Defined:
  - LINE stops after writing column IMG_W-1 of the starting row, even if L is not exhausted.
  - result reports the clipped count, min(L, IMG_W-x).
  - done arrives the cycle after the last actual write.
- Undefined:
  - Lines run linearly across rows with 12-bit address wrap, as described above.

Test Plan:
- Reset, then PIXEL x=5, y=3, value=1
  - -> one wren cycle at wraddress=197, data=1; done 2 cycles after accept; result=1; busy low at done.
- FILL value=0
  - -> 4096 consecutive wren cycles, addresses 0..4095; done at k+4097; result=4096; STATUS then returns total=4097.
- LINE x=60, y=2, L=10, value=1
  - Without macro -> addresses 188..197, result=10.
  - With HLINE_CLIP_EN -> addresses 188..191, result=4.
- LINE x=63, y=63, L=3, without macro
  - -> addresses 4095, 0, 1 (wrap); result=3.
  - Also LINE L=0 -> no wren; done at k+1; result=0.
- Assert start repeatedly during a FILL
  - -> ignored; only the FILL completes.
  - start held high across done -> new command accepted the cycle after done.
- Drive reset_n=0 at write 100 of a FILL
  - -> wren=0 immediately; no done; after release STATUS returns result=0.
